// File: rtl/hazard_mdu_pkg.sv
// Shared definitions for the hazard/MDU unit: register-address width,
// forwarding-select encodings and the MDU tracker state encoding.
package hazard_mdu_pkg;

    // 32 general-purpose registers.
    localparam int REGW = 5;

    // E-stage ALU operand source selects.
    localparam logic [1:0] FWD_RF = 2'b00;  // register file
    localparam logic [1:0] FWD_M  = 2'b10;  // M-stage result
    localparam logic [1:0] FWD_W  = 2'b01;  // W-stage result

    // MDU tracker states.
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/hazard_mdu_md_tracker.sv
// Iterative multiply/divide occupancy tracker.
// Loads MDU_LAT when an op issues from E, counts down while busy, and
// returns to idle after the last busy cycle with a one-cycle done pulse.
module md_tracker
    import hazard_mdu_pkg::*;
#(
    parameter int MDU_LAT = 4,
    parameter int LATW    = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    output logic o_busy,
    output logic o_done
);

    md_state_e          r_state;
    logic [LATW-1:0]    r_cnt;
    logic               r_busy;
    logic               r_done;

    // IDLE/BUSY FSM with latency counter; busy/done are registered.
    // A start while already busy cannot happen (the op is held in D),
    // so it is simply ignored rather than reloading the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    if (i_start) begin
                        r_state <= MD_BUSY;
                        r_cnt   <= LATW'(MDU_LAT);
                        r_busy  <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (r_cnt == LATW'(1)) begin
                        r_state <= MD_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - LATW'(1);
                    end
                end
                default: begin
                    r_state <= MD_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: rtl/hazard_mdu.sv
// Pipeline hazard unit for the 5-stage MIPS core with MDU tracking.
// Forwarding selects and stall conditions are combinational; the MDU
// occupancy and the saturating stall-cycle counter are registered.
module hazard_mdu #(
    parameter int REGW    = hazard_mdu_pkg::REGW,
    parameter int MDU_LAT = 4,
    parameter int LATW    = 3,
    parameter int PCW     = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            regwriteE,
    input  logic            regwriteM,
    input  logic            regwriteW,
    input  logic            memtoregE,
    input  logic            memtoregM,
    input  logic            branchD,
    input  logic [REGW-1:0] rsD,
    input  logic [REGW-1:0] rtD,
    input  logic [REGW-1:0] rsE,
    input  logic [REGW-1:0] rtE,
    input  logic [REGW-1:0] writeregE,
    input  logic [REGW-1:0] writeregM,
    input  logic [REGW-1:0] writeregW,
    input  logic            mdstartE,
    input  logic            mdstartD,
    input  logic            mdreadD,
    output logic            forwardAD,
    output logic            forwardBD,
    output logic            forwardADW,
    output logic            forwardBDW,
    output logic [1:0]      forwardAE,
    output logic [1:0]      forwardBE,
    output logic            stallF,
    output logic            stallD,
    output logic            flushE,
    output logic            mdbusy,
    output logic [PCW-1:0]  stallcnt
);

    import hazard_mdu_pkg::*;

    // A writing stage produces the value a reader needs; $zero never matches.
    function automatic logic f_hit(input logic            wr,
                                   input logic [REGW-1:0] dst,
                                   input logic [REGW-1:0] src);
        return wr && (src != '0) && (src == dst);
    endfunction

    logic           w_lwstall;
    logic           w_brstall;
    logic           w_mdstall;
    logic           w_stall;
    logic           w_md_busy;
    logic           w_md_done;
    logic [PCW-1:0] r_stallcnt;

    // D-stage compare operand forwarding from M and W.
    always_comb begin
        forwardAD  = f_hit(regwriteM, writeregM, rsD);
        forwardBD  = f_hit(regwriteM, writeregM, rtD);
        forwardADW = f_hit(regwriteW, writeregW, rsD);
        forwardBDW = f_hit(regwriteW, writeregW, rtD);
    end

    // E-stage ALU operand selects; the younger M result wins over W.
    always_comb begin
        forwardAE = FWD_RF;
        forwardBE = FWD_RF;
        if (f_hit(regwriteM, writeregM, rsE))
            forwardAE = FWD_M;
        else if (f_hit(regwriteW, writeregW, rsE))
            forwardAE = FWD_W;
        if (f_hit(regwriteM, writeregM, rtE))
            forwardBE = FWD_M;
        else if (f_hit(regwriteW, writeregW, rtE))
            forwardBE = FWD_W;
    end

    // Stall sources: load-use, branch compare on an in-flight result,
    // and MDU access while the unit is (or is about to be) busy.
    always_comb begin
        w_lwstall = memtoregE && (rtE != '0) && ((rsD == rtE) || (rtD == rtE));
        w_brstall = branchD &&
                    (f_hit(regwriteE, writeregE, rsD) || f_hit(regwriteE, writeregE, rtD) ||
                     f_hit(memtoregM, writeregM, rsD) || f_hit(memtoregM, writeregM, rtD));
        w_mdstall = (mdreadD || mdstartD) && (w_md_busy || mdstartE);
        w_stall   = w_lwstall || w_brstall || w_mdstall;
    end

    assign stallF = w_stall;
    assign stallD = w_stall;
    assign flushE = w_stall;

    md_tracker #(
        .MDU_LAT (MDU_LAT),
        .LATW    (LATW)
    ) u_md_tracker (
        .clk     (clk),
        .reset   (reset),
        .i_start (mdstartE),
        .o_busy  (w_md_busy),
        .o_done  (w_md_done)
    );

    assign mdbusy = w_md_busy;

    // Saturating count of stalled cycles for performance monitoring.
    always_ff @(posedge clk) begin
        if (reset)
            r_stallcnt <= '0;
        else if (w_stall && (r_stallcnt != {PCW{1'b1}}))
            r_stallcnt <= r_stallcnt + PCW'(1);
    end

    assign stallcnt = r_stallcnt;

    // The done pulse lands in the first idle cycle after an op completes.
    a_done_idle: assert property (@(posedge clk) disable iff (reset) w_md_done |-> !w_md_busy);

endmodule

// File: tb/tb_hazard_mdu.sv
// Self-checking bench for hazard_mdu: three instances (LAT=4/PCW=4,
// LAT=4/PCW=16, LAT=1/PCW=16) share one stimulus stream and are compared
// every cycle against a behavioural model; directed cases pin the model.
module tb_hazard_mdu;

    logic       clk = 1'b0;
    logic       reset;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       mdstartE, mdstartD, mdreadD;

    logic       fAD[3], fBD[3], fADW[3], fBDW[3];
    logic [1:0] fAE[3], fBE[3];
    logic       sF[3], sD[3], fE[3], mb[3];
    logic [3:0]  cnt0;
    logic [15:0] cnt1, cnt2;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state: remaining busy cycles and expected stall count per instance.
    int LAT[3] = '{4, 4, 1};
    int MAXC[3] = '{15, 65535, 65535};
    int rem[3] = '{0, 0, 0};
    int mc[3]  = '{0, 0, 0};

    always #5 clk = ~clk;

    hazard_mdu #(.MDU_LAT(4), .LATW(3), .PCW(4)) u0 (
        .clk(clk), .reset(reset), .regwriteE(regwriteE), .regwriteM(regwriteM),
        .regwriteW(regwriteW), .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .mdstartE(mdstartE), .mdstartD(mdstartD), .mdreadD(mdreadD),
        .forwardAD(fAD[0]), .forwardBD(fBD[0]), .forwardADW(fADW[0]), .forwardBDW(fBDW[0]),
        .forwardAE(fAE[0]), .forwardBE(fBE[0]), .stallF(sF[0]), .stallD(sD[0]),
        .flushE(fE[0]), .mdbusy(mb[0]), .stallcnt(cnt0));

    hazard_mdu #(.MDU_LAT(4), .LATW(3), .PCW(16)) u1 (
        .clk(clk), .reset(reset), .regwriteE(regwriteE), .regwriteM(regwriteM),
        .regwriteW(regwriteW), .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .mdstartE(mdstartE), .mdstartD(mdstartD), .mdreadD(mdreadD),
        .forwardAD(fAD[1]), .forwardBD(fBD[1]), .forwardADW(fADW[1]), .forwardBDW(fBDW[1]),
        .forwardAE(fAE[1]), .forwardBE(fBE[1]), .stallF(sF[1]), .stallD(sD[1]),
        .flushE(fE[1]), .mdbusy(mb[1]), .stallcnt(cnt1));

    hazard_mdu #(.MDU_LAT(1), .LATW(3), .PCW(16)) u2 (
        .clk(clk), .reset(reset), .regwriteE(regwriteE), .regwriteM(regwriteM),
        .regwriteW(regwriteW), .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .mdstartE(mdstartE), .mdstartD(mdstartD), .mdreadD(mdreadD),
        .forwardAD(fAD[2]), .forwardBD(fBD[2]), .forwardADW(fADW[2]), .forwardBDW(fBDW[2]),
        .forwardAE(fAE[2]), .forwardBE(fBE[2]), .stallF(sF[2]), .stallD(sD[2]),
        .flushE(fE[2]), .mdbusy(mb[2]), .stallcnt(cnt2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit hit(input logic wr, input logic [4:0] dst, input logic [4:0] src);
        return wr && (src != 0) && (src == dst);
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] src);
        if (hit(regwriteM, writeregM, src)) return 2'b10;
        if (hit(regwriteW, writeregW, src)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit exp_stall(input int k);
        bit lw, br, md;
        lw = memtoregE && (rtE != 0) && (rsD == rtE || rtD == rtE);
        br = branchD && ((regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD)) ||
                         (memtoregM && writeregM != 0 && (writeregM == rsD || writeregM == rtD)));
        md = (mdreadD || mdstartD) && (rem[k] > 0 || mdstartE);
        return lw || br || md;
    endfunction

    function automatic logic [31:0] cntv(input int k);
        if (k == 0) return {28'd0, cnt0};
        if (k == 1) return {16'd0, cnt1};
        return {16'd0, cnt2};
    endfunction

    // Model advance at each active edge.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            bit st;
            st = exp_stall(k);
            if (reset) begin
                rem[k] = 0;
                mc[k]  = 0;
            end else begin
                mc[k] = (mc[k] + int'(st) > MAXC[k]) ? MAXC[k] : mc[k] + int'(st);
                if (rem[k] > 0) rem[k] = rem[k] - 1;
                else if (mdstartE) rem[k] = LAT[k];
            end
        end
    end

    // Full output comparison on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                bit st;
                st = exp_stall(k);
                chk($sformatf("u%0d.forwardAD", k),  32'(fAD[k]),  32'(hit(regwriteM, writeregM, rsD)));
                chk($sformatf("u%0d.forwardBD", k),  32'(fBD[k]),  32'(hit(regwriteM, writeregM, rtD)));
                chk($sformatf("u%0d.forwardADW", k), 32'(fADW[k]), 32'(hit(regwriteW, writeregW, rsD)));
                chk($sformatf("u%0d.forwardBDW", k), 32'(fBDW[k]), 32'(hit(regwriteW, writeregW, rtD)));
                chk($sformatf("u%0d.forwardAE", k),  32'(fAE[k]),  32'(fsel(rsE)));
                chk($sformatf("u%0d.forwardBE", k),  32'(fBE[k]),  32'(fsel(rtE)));
                chk($sformatf("u%0d.stallF", k),     32'(sF[k]),   32'(st));
                chk($sformatf("u%0d.stallD", k),     32'(sD[k]),   32'(st));
                chk($sformatf("u%0d.flushE", k),     32'(fE[k]),   32'(st));
                chk($sformatf("u%0d.mdbusy", k),     32'(mb[k]),   32'(rem[k] > 0));
                chk($sformatf("u%0d.stallcnt", k),   cntv(k),      32'(mc[k]));
            end
        end
    end

    task automatic clr();
        regwriteE = 0; regwriteM = 0; regwriteW = 0; memtoregE = 0; memtoregM = 0;
        branchD = 0; rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        mdstartE = 0; mdstartD = 0; mdreadD = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        @(negedge clk);
        chk("reset.mdbusy", 32'(mb[1]), 32'd0);
        chk("reset.stallcnt", 32'(cnt1), 32'd0);
        chk("reset.stallcnt_p4", 32'(cnt0), 32'd0);

        // Load-use stall, then release.
        step();
        reset = 1'b0;
        memtoregE = 1; rtE = 8; rsD = 8;
        @(negedge clk);
        chk("lw.stallF", 32'(sF[1]), 32'd1);
        chk("lw.stallD", 32'(sD[1]), 32'd1);
        chk("lw.flushE", 32'(fE[1]), 32'd1);
        step();
        clr();
        @(negedge clk);
        chk("lw.release", 32'(sD[1]), 32'd0);
        chk("lw.stallcnt", 32'(cnt1), 32'd1);

        // Forward priority and branch stalls, all inside one cycle.
        step();
        regwriteM = 1; regwriteW = 1; writeregM = 9; writeregW = 9; rsE = 9;
        #1 chk("fwd.M", 32'(fAE[1]), 32'd2);
        regwriteM = 0;
        #1 chk("fwd.W", 32'(fAE[1]), 32'd1);
        regwriteM = 1; writeregM = 0; writeregW = 0; rsE = 0;
        #1 chk("fwd.r0", 32'(fAE[1]), 32'd0);
        clr();
        branchD = 1; rsD = 4; regwriteE = 1; writeregE = 4;
        #1 chk("br.E", 32'(sD[1]), 32'd1);
        regwriteE = 0; memtoregM = 1; writeregM = 4;
        #1 chk("br.M", 32'(sD[1]), 32'd1);
        regwriteE = 1; writeregE = 0; rsD = 0;
        #1 chk("br.r0", 32'(sD[1]), 32'd0);
        clr();
        @(negedge clk);

        // MDU op with mfhi waiting in D; stallcnt starts from 1 here.
        step();
        mdstartE = 1; mdreadD = 1;
        @(negedge clk);
        chk("md.c0.busy", 32'(mb[1]), 32'd0);
        chk("md.c0.stall", 32'(sD[1]), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            step();
            mdstartE = 0;
            @(negedge clk);
            chk($sformatf("md.c%0d.busy", c), 32'(mb[1]), 32'd1);
            chk($sformatf("md.c%0d.stall", c), 32'(sD[1]), 32'd1);
            if (c == 1) chk("md1.c1.busy", 32'(mb[2]), 32'd1);
            if (c == 2) chk("md1.c2.busy", 32'(mb[2]), 32'd0);
        end
        step();
        @(negedge clk);
        chk("md.c5.busy", 32'(mb[1]), 32'd0);
        chk("md.c5.stall", 32'(sD[1]), 32'd0);
        chk("md.stallcnt", 32'(cnt1), 32'd6);
        chk("md1.stallcnt", 32'(cnt2), 32'd3);

        // Reset in the middle of a busy period.
        step();
        clr();
        mdstartE = 1;
        step();
        mdstartE = 0;
        step();
        reset = 1; mdreadD = 1;
        step();
        reset = 0;
        @(negedge clk);
        chk("rst.mdbusy", 32'(mb[1]), 32'd0);
        chk("rst.stallcnt", 32'(cnt1), 32'd0);
        chk("rst.stall", 32'(sD[1]), 32'd0);

        // Saturation of the 4-bit counter.
        step();
        clr();
        memtoregE = 1; rtE = 8; rsD = 8;
        repeat (20) step();
        @(negedge clk);
        chk("sat.p4", 32'(cnt0), 32'd15);
        chk("sat.p16", 32'(cnt1), 32'd20);
        step();
        @(negedge clk);
        chk("sat.hold", 32'(cnt0), 32'd15);
        chk("sat.p16b", 32'(cnt1), 32'd21);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            step();
            reset     = ($urandom_range(0, 149) == 0);
            regwriteE = $urandom_range(0, 1) == 1;
            regwriteM = $urandom_range(0, 1) == 1;
            regwriteW = $urandom_range(0, 1) == 1;
            memtoregE = $urandom_range(0, 3) == 0;
            memtoregM = $urandom_range(0, 3) == 0;
            branchD   = $urandom_range(0, 3) == 0;
            rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
            writeregE = 5'($urandom_range(0, 3));
            writeregM = 5'($urandom_range(0, 3));
            writeregW = 5'($urandom_range(0, 3));
            mdstartE  = $urandom_range(0, 5) == 0;
            mdstartD  = $urandom_range(0, 5) == 0;
            mdreadD   = $urandom_range(0, 4) == 0;
        end
        step();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_mdu.md
Name: hazard_mdu

Overview:
Parametrised successor to the pipeline hazard unit for the 5-stage MIPS core. It does three things:
- Computes the combinational D- and E-stage forwarding selects.
- Raises load-use and branch-compare stalls.
- Tracks an iterative multiply/divide unit (MDU) with a latency counter, so mfhi/mflo and back-to-back mult/div stall until HI/LO are ready.
It also keeps a saturating stall-cycle counter for performance monitoring. It sits beside the datapath and drives stallF/stallD/flushE to the pipeline registers.

Parameters:
REGW, 5, register-address width (32 GPRs).
MDU_LAT, 4, MDU cycles from issue in E until HI/LO are valid; legal range 1..(2^LATW - 1).
LATW, 3, width of the MDU latency counter.
PCW, 16, width of the stall-cycle performance counter.

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
regwriteE, regwriteM, regwriteW  in  1  stage writes a GPR
memtoregE, memtoregM  in  1  stage is a load
branchD  in  1  branch/compare in D
rsD, rtD, rsE, rtE  in  REGW  source register numbers
writeregE, writeregM, writeregW  in  REGW  destination register numbers
mdstartE  in  1  mult/div in E (issues to MDU this cycle)
mdstartD  in  1  mult/div in D
mdreadD  in  1  mfhi/mflo in D
forwardAD, forwardBD  out  1  D-compare operand from M result
forwardADW, forwardBDW  out  1  D-compare operand from W result
forwardAE, forwardBE  out  2  E ALU operand: 00 regfile, 10 M, 01 W
stallF, stallD, flushE  out  1  pipeline control
mdbusy  out  1  MDU computing
stallcnt  out  PCW  cumulative stalled cycles, saturating

Behaviour:
Forwarding (combinational):
- forwardAD = regwriteM & rsD!=0 & rsD==writeregM. forwardBD likewise with rtD.
- forwardADW/BDW use the same rule against W.
- forwardAE = 10 if the M match holds, else 01 if the W match holds, else 00. M has priority. forwardBE likewise with rtE.
- Register 0 never forwards and never causes a stall.

Stalls (combinational):
- lwstall = memtoregE & rtE!=0 & (rsD==rtE | rtD==rtE).
- brstall = branchD & [ (regwriteE & writeregE!=0 & writeregE∈{rsD,rtD}) | (memtoregM & writeregM!=0 & writeregM∈{rsD,rtD}) ].
- mdstall = (mdreadD | mdstartD) & (mdbusy | mdstartE).
- stallD = stallF = flushE = lwstall | brstall | mdstall.

MDU tracker (sequential; states IDLE, BUSY; cnt is LATW bits):
- IDLE & mdstartE: cnt<=MDU_LAT, go to BUSY.
- BUSY: cnt<=cnt-1 each cycle. When cnt==1, go to IDLE next cycle with cnt<=0.
- mdbusy = (state==BUSY).
- mdstartE while BUSY cannot occur, because mdstall holds the op in D. The tracker ignores it: no reload, no state change.
- MDU_LAT=1: BUSY lasts exactly one cycle.
- The D instruction is released in the cycle after mdbusy falls.

Performance counter:
- stallcnt increments by 1 every cycle that stallD=1.
- It saturates at 2^PCW-1 and does not wrap.

Reset:
- On a clk edge with reset=1: state<=IDLE, cnt<=0, stallcnt<=0, mdbusy=0.
- Reset mid-BUSY aborts tracking immediately.
- Combinational outputs follow the inputs during reset. The pipeline is flushed externally.

Decomposition:
- Shared package holds REGW, the forward-select encodings (FWD_RF=00, FWD_M=10, FWD_W=01), and the MDU state encoding.
- The natural sub-module is md_tracker: the IDLE/BUSY FSM plus counter, with outputs mdbusy and a done pulse.
- Forwarding and stall logic stay flat in hazard_mdu.

Test Plan:
- Load-use: memtoregE=1, rtE=8, rsD=8 → stallF=stallD=flushE=1. Next cycle with memtoregE=0 → all 0, and stallcnt advanced by 1.
- Forward priority: regwriteM=regwriteW=1, writeregM=writeregW=rsE=9 → forwardAE=10. With regwriteM=0 → 01. With rsE=0 → 00 even when writeregM=0.
- Branch stall: branchD=1, rsD=4, regwriteE=1, writeregE=4 → stallD=1. The same case with memtoregM=1, writeregM=4 → stallD=1. With writeregE=0 and rsD=0 → stallD=0.
- MDU, MDU_LAT=4: mdstartE pulse at cycle 0 → mdbusy=1 in cycles 1–4, 0 at cycle 5. mdreadD held from cycle 0 → stallD=1 in cycles 0–4, 0 at cycle 5. stallcnt=5.
- Reset mid-op: assert reset in cycle 2 of BUSY → next cycle mdbusy=0, stallcnt=0, and mdreadD no longer stalls.
- Saturation: run with PCW=4 and stallD forced high for 20 cycles → stallcnt=15 and holds.
